apb_master: RTL

Single-slave APB requester. It converts a simple valid/ready request port from the system side into APB SETUP/ACCESS cycles toward the memory slave. It holds address, data and direction stable across wait states. Each transfer returns exactly one response pulse carrying read data and an error flag.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_wait_timer.sv | 28 ++
 rtl/apb_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the single-slave APB requester.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_c flags the cycle on which the count would reach TIMEOUT.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = cnt_en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-slave APB requester: valid/ready request port to APB SETUP/ACCESS cycles.
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              PREADY
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  apb_state_t        state, state_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d;
  logic              load;
  logic              timer_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .clear     (state == SETUP),
    .cnt_en    ((state == ACCESS) && !PREADY),
    .expired_c (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // Ready is open in IDLE and on the completing ACCESS cycle for back-to-back issue.
  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      ACCESS:  req_ready = PREADY;
      default: req_ready = 1'b0;
    endcase
  end

  assign load = req_valid && req_ready;

  always_comb begin
    state_d     = state;
    psel_d      = PSEL1;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    if (load) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
    end

    case (state)
      IDLE: begin
        if (load) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = PWRITE ? '0 : prdata;
          rsp_err_d   = 1'b0;
          state_d     = load ? SETUP : IDLE;
          psel_d      = load;
          penable_d   = 1'b0;
        end else if (timer_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL1     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      PSEL1     <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
